// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the I-cache and D-cache
// miss paths. It grants one requester at a time, sequences the memory
// handshake and returns a one-cycle done pulse carrying the read data.
// Saturating counters record grants and IDLE-cycle conflicts.
//
// Handshake summary:
// - Requester side: req is held high until the matching done pulse. req must
//   drop in the cycle after done; a req still high then is a new request.
//   Requester inputs are sampled only while the arbiter is IDLE.
// - Memory side: mem_req is held high with stable mem_wr/mem_addr/mem_wdata
//   until a single-cycle mem_ready arrives. mem_rdata is valid with
//   mem_ready. mem_ready outside BUSY is ignored.
module mem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 64,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] rdata,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          err,
  output logic [CW-1:0] i_grant_cnt,
  output logic [CW-1:0] d_grant_cnt,
  output logic [CW-1:0] conflict_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Owner encoding: 0 = I-cache, 1 = D-cache.
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Timeout counter counts 0 .. TIMEOUT-1 inside BUSY.
  localparam int TW_RAW = $clog2(TIMEOUT + 1);
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] C_MAX  = {CW{1'b1}};

  state_t        state;
  logic          owner;
  logic          lastOwner;
  logic [TW-1:0] timeoutCnt;
  logic          grantD;
  logic          anyReq;
  logic          bothReq;
  logic          grantEvent;

  assign anyReq     = i_req | d_req;
  assign bothReq    = i_req & d_req;
  assign grantEvent = (state == IDLE) & anyReq;

  // Arbitration: a lone requester wins; on a tie the non-last owner wins.
  always_comb begin
    grantD = 1'b0;
    if (d_req && !i_req) begin
      grantD = 1'b1;
    end else if (bothReq) begin
      grantD = (lastOwner == OWN_I);
    end
  end

  // Main FSM with all handshake outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_I;
      lastOwner  <= OWN_I;
      timeoutCnt <= '0;
      mem_req    <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      rdata      <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            owner      <= grantD;
            mem_req    <= 1'b1;
            mem_wr     <= grantD & d_wr;
            mem_addr   <= grantD ? d_addr : i_addr;
            mem_wdata  <= (grantD && d_wr) ? d_wdata : '0;
            timeoutCnt <= '0;
            busy       <= 1'b1;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            // Writes return zero data to the requester.
            rdata     <= mem_wr ? '0 : mem_rdata;
            lastOwner <= owner;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            i_done    <= (owner == OWN_I);
            d_done    <= (owner == OWN_D);
            state     <= DONE;
          end else if (timeoutCnt == T_LAST) begin
            // Abort so the requester does not hang; err stays set until reset.
            err       <= 1'b1;
            rdata     <= '0;
            lastOwner <= owner;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            i_done    <= (owner == OWN_I);
            d_done    <= (owner == OWN_D);
            state     <= DONE;
          end else begin
            timeoutCnt <= timeoutCnt + TW'(1);
          end
        end
        DONE: begin
          rdata <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          mem_wr  <= 1'b0;
          rdata   <= '0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Saturating performance counters, updated at each IDLE grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_grant_cnt  <= '0;
      d_grant_cnt  <= '0;
      conflict_cnt <= '0;
    end else if (grantEvent) begin
      if (grantD) begin
        if (d_grant_cnt != C_MAX) d_grant_cnt <= d_grant_cnt + CW'(1);
      end else begin
        if (i_grant_cnt != C_MAX) i_grant_cnt <= i_grant_cnt + CW'(1);
      end
      if (bothReq && conflict_cnt != C_MAX) begin
        conflict_cnt <= conflict_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (TIMEOUT=4). Inputs are driven and
// outputs sampled 1ns after the rising clock edge.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int CW = 16;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_done;
  logic          d_req = 1'b0;
  logic          d_wr = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_done;
  logic [DW-1:0] rdata;
  logic          mem_req;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          busy;
  logic          err;
  logic [CW-1:0] i_grant_cnt;
  logic [CW-1:0] d_grant_cnt;
  logic [CW-1:0] conflict_cnt;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
    .rdata(rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .err(err),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .conflict_cnt(conflict_cnt)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if ({i_done, d_done} !== 2'b00) begin fails++; $display("FAIL reset_done got %b exp 00", {i_done, d_done}); end
    checks++; if (rdata !== 16'h0) begin fails++; $display("FAIL reset_rdata got %h exp 0000", rdata); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if ({i_grant_cnt, d_grant_cnt, conflict_cnt} !== 48'h0) begin fails++; $display("FAIL reset_cnts got %h %h %h exp 0", i_grant_cnt, d_grant_cnt, conflict_cnt); end
  endtask

  task automatic test_i_read();
    // cycle 0: request
    i_req = 1'b1; i_addr = 16'h0040;
    tick(); // cycle 1
    checks++; if (mem_req !== 1'b1) begin fails++; $display("FAIL iread_mem_req got %b exp 1", mem_req); end
    checks++; if (mem_wr !== 1'b0) begin fails++; $display("FAIL iread_mem_wr got %b exp 0", mem_wr); end
    checks++; if (mem_addr !== 16'h0040) begin fails++; $display("FAIL iread_mem_addr got %h exp 0040", mem_addr); end
    tick(); // cycle 2
    checks++; if (i_done !== 1'b0) begin fails++; $display("FAIL iread_early_done got %b exp 0", i_done); end
    tick(); // cycle 3: memory answers
    mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    tick(); // cycle 4
    mem_ready = 1'b0; mem_rdata = 16'h0000;
    checks++; if (i_done !== 1'b1) begin fails++; $display("FAIL iread_i_done got %b exp 1", i_done); end
    checks++; if (d_done !== 1'b0) begin fails++; $display("FAIL iread_d_done got %b exp 0", d_done); end
    checks++; if (rdata !== 16'hBEEF) begin fails++; $display("FAIL iread_rdata got %h exp beef", rdata); end
    i_req = 1'b0;
    tick(); // cycle 5
    checks++; if (i_done !== 1'b0) begin fails++; $display("FAIL iread_pulse_len got %b exp 0", i_done); end
    checks++; if (rdata !== 16'h0) begin fails++; $display("FAIL iread_rdata_clear got %h exp 0000", rdata); end
    checks++; if (i_grant_cnt !== 16'd1) begin fails++; $display("FAIL iread_i_grant_cnt got %0d exp 1", i_grant_cnt); end
    // A stray mem_ready in IDLE must not cause a done pulse.
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    checks++; if ({i_done, d_done, busy} !== 3'b000) begin fails++; $display("FAIL idle_ready_ignored got %b exp 000", {i_done, d_done, busy}); end
  endtask

  task automatic test_d_write();
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h1234; d_wdata = 16'hA5A5;
    tick(); // cycle 1
    checks++; if (mem_wr !== 1'b1) begin fails++; $display("FAIL dwr_mem_wr got %b exp 1", mem_wr); end
    checks++; if (mem_wdata !== 16'hA5A5) begin fails++; $display("FAIL dwr_mem_wdata got %h exp a5a5", mem_wdata); end
    checks++; if (mem_addr !== 16'h1234) begin fails++; $display("FAIL dwr_mem_addr got %h exp 1234", mem_addr); end
    mem_ready = 1'b1; mem_rdata = 16'h7777;
    tick(); // cycle 2
    mem_ready = 1'b0; mem_rdata = 16'h0000;
    checks++; if (d_done !== 1'b1) begin fails++; $display("FAIL dwr_d_done got %b exp 1", d_done); end
    checks++; if (i_done !== 1'b0) begin fails++; $display("FAIL dwr_i_done got %b exp 0", i_done); end
    checks++; if (rdata !== 16'h0) begin fails++; $display("FAIL dwr_rdata got %h exp 0000", rdata); end
    d_req = 1'b0; d_wr = 1'b0;
    tick();
    checks++; if (d_grant_cnt !== 16'd1) begin fails++; $display("FAIL dwr_d_grant_cnt got %0d exp 1", d_grant_cnt); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    i_req = 1'b1; i_addr = 16'h0100;
    d_req = 1'b1; d_addr = 16'h0200; d_wr = 1'b0;
    tick(); // first grant should be D
    checks++; if (mem_addr !== 16'h0200) begin fails++; $display("FAIL sim_first_addr got %h exp 0200", mem_addr); end
    checks++; if (conflict_cnt !== 16'd1) begin fails++; $display("FAIL sim_conflict1 got %0d exp 1", conflict_cnt); end
    mem_ready = 1'b1; mem_rdata = 16'h1111;
    tick();
    mem_ready = 1'b0;
    checks++; if ({i_done, d_done} !== 2'b01) begin fails++; $display("FAIL sim_first_done got %b exp 01", {i_done, d_done}); end
    checks++; if (rdata !== 16'h1111) begin fails++; $display("FAIL sim_first_rdata got %h exp 1111", rdata); end
    tick(); // IDLE, both still high
    tick(); // second grant should be I
    checks++; if (mem_addr !== 16'h0100) begin fails++; $display("FAIL sim_second_addr got %h exp 0100", mem_addr); end
    checks++; if (conflict_cnt !== 16'd2) begin fails++; $display("FAIL sim_conflict2 got %0d exp 2", conflict_cnt); end
    mem_ready = 1'b1; mem_rdata = 16'h2222;
    tick();
    mem_ready = 1'b0;
    checks++; if ({i_done, d_done} !== 2'b10) begin fails++; $display("FAIL sim_second_done got %b exp 10", {i_done, d_done}); end
    checks++; if (rdata !== 16'h2222) begin fails++; $display("FAIL sim_second_rdata got %h exp 2222", rdata); end
    i_req = 1'b0; d_req = 1'b0;
    tick();
    checks++; if ({i_grant_cnt, d_grant_cnt} !== {16'd1, 16'd1}) begin fails++; $display("FAIL sim_grant_cnts got i=%0d d=%0d exp 1 1", i_grant_cnt, d_grant_cnt); end
  endtask

  task automatic test_contention();
    logic exp_d;
    do_reset();
    i_req = 1'b1; i_addr = 16'h0A00;
    d_req = 1'b1; d_addr = 16'h0D00; d_wr = 1'b0;
    for (int t = 0; t < 6; t++) begin
      exp_d = (t % 2 == 0);
      tick(); // BUSY
      checks++; if (mem_addr !== (exp_d ? 16'h0D00 : 16'h0A00)) begin fails++; $display("FAIL cont_addr_%0d got %h exp %h", t, mem_addr, exp_d ? 16'h0D00 : 16'h0A00); end
      mem_ready = 1'b1; mem_rdata = 16'(16'h3000 + t);
      tick(); // DONE
      mem_ready = 1'b0;
      checks++; if ({i_done, d_done} !== {~exp_d, exp_d}) begin fails++; $display("FAIL cont_done_%0d got %b exp %b", t, {i_done, d_done}, {~exp_d, exp_d}); end
      checks++; if (rdata !== 16'(16'h3000 + t)) begin fails++; $display("FAIL cont_rdata_%0d got %h exp %h", t, rdata, 16'(16'h3000 + t)); end
      if (t == 5) begin
        i_req = 1'b0; d_req = 1'b0;
      end
      tick(); // IDLE
    end
    checks++; if (conflict_cnt !== 16'd6) begin fails++; $display("FAIL cont_conflict got %0d exp 6", conflict_cnt); end
    checks++; if ({i_grant_cnt, d_grant_cnt} !== {16'd3, 16'd3}) begin fails++; $display("FAIL cont_grants got i=%0d d=%0d exp 3 3", i_grant_cnt, d_grant_cnt); end
  endtask

  task automatic test_timeout();
    int n;
    i_req = 1'b1; i_addr = 16'h0300;
    tick();
    n = 0;
    while (mem_req === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    checks++; if (n !== 4) begin fails++; $display("FAIL tmo_busy_cycles got %0d exp 4", n); end
    checks++; if (i_done !== 1'b1) begin fails++; $display("FAIL tmo_i_done got %b exp 1", i_done); end
    checks++; if (rdata !== 16'h0) begin fails++; $display("FAIL tmo_rdata got %h exp 0000", rdata); end
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL tmo_err got %b exp 1", err); end
    i_req = 1'b0;
    tick();
    // A good D read afterwards: err must stay set.
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0400;
    tick();
    mem_ready = 1'b1; mem_rdata = 16'h5A5A;
    tick();
    mem_ready = 1'b0;
    checks++; if ({d_done, rdata} !== {1'b1, 16'h5A5A}) begin fails++; $display("FAIL tmo_good_read got %b %h exp 1 5a5a", d_done, rdata); end
    d_req = 1'b0;
    tick();
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL tmo_err_sticky got %b exp 1", err); end
  endtask

  task automatic test_reset_mid();
    int dones;
    i_req = 1'b1; i_addr = 16'h0500;
    tick(); // BUSY
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL rmid_busy_before got %b exp 1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({mem_req, busy, i_done, d_done} !== 4'b0000) begin fails++; $display("FAIL rmid_async_drop got %b exp 0000", {mem_req, busy, i_done, d_done}); end
    checks++; if ({i_grant_cnt, d_grant_cnt, conflict_cnt} !== 48'h0) begin fails++; $display("FAIL rmid_cnts got %h %h %h exp 0", i_grant_cnt, d_grant_cnt, conflict_cnt); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL rmid_err got %b exp 0", err); end
    i_req = 1'b0;
    tick();
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      mem_ready = (k == 1);
      tick();
      if (i_done === 1'b1 || d_done === 1'b1) dones++;
    end
    mem_ready = 1'b0;
    checks++; if (dones !== 0) begin fails++; $display("FAIL rmid_no_done got %0d exp 0", dones); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_simultaneous();
    test_contention();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
